pipe_stage_buf: RTL and testbench

- Parametrised elastic pipeline-stage register; successor to the fixed-field inter-stage latches.
- Carries an opaque DATA_W-bit stage payload (control and data fields packed by the instantiating stage).
- Holds up to DEPTH payloads in a FIFO using a valid/ready handshake.
- Supports flush-to-bubble, a hold (freeze) input, and a saturating counter of flushed entries.
- Sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) in the datapath.

---
 rtl/pipe_stage_buf.sv | 101 ++++++++++
 tb/tb_pipe_stage_buf.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage buffer: a DEPTH-entry valid/ready FIFO between two datapath
// stages, with flush-to-bubble, a freeze input and a saturating count of flushed entries.
module pipe_stage_buf #(
  parameter int                DATA_W     = 32,
  parameter int                DEPTH      = 2,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
  parameter int                CNT_W      = 16
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  input  logic                       flush,
  input  logic                       hold,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [CNT_W-1:0]           flush_drops
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = ((CNT_W > CW) ? CNT_W : CW) + 1;
  localparam logic [CNT_W-1:0] DROP_MAX = {CNT_W{1'b1}};

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CNT_W-1:0]  drops_q, drops_d;
  logic [CW-1:0]     dropInc;
  logic [SW-1:0]     dropSum;
  logic              notEmpty;
  logic              push;
  logic              pop;

  function automatic logic [PW-1:0] ptrInc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A single-entry stage must accept a replacement while full, otherwise it halves throughput.
  always_comb begin
    notEmpty  = (count_q != '0);
    out_valid = notEmpty && !hold;
    out_data  = notEmpty ? mem_q[head_q] : BUBBLE_VAL;
    if (hold) begin
      in_ready = 1'b0;
    end else if (DEPTH == 1) begin
      in_ready = !notEmpty || out_ready;
    end else begin
      in_ready = (count_q < CW'(DEPTH));
    end
  end

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    drops_d = drops_q;
    dropInc = count_q - CW'(pop);
    dropSum = SW'(drops_q) + SW'(dropInc);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      drops_d = (dropSum > SW'(DROP_MAX)) ? DROP_MAX : dropSum[CNT_W-1:0];
    end else begin
      if (push) tail_d = ptrInc(tail_q);
      if (pop)  head_d = ptrInc(head_q);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      drops_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      drops_q <= drops_d;
    end
  end

  // Payload storage is never reset; occupancy alone decides what is visible.
  always_ff @(posedge CLK) begin
    if (push && !flush) mem_q[tail_q] <= in_data;
  end

  assign count       = count_q;
  assign flush_drops = drops_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: three configurations share one stimulus stream and are
// compared every cycle against a list-based model of the buffer's rules.
module tb_pipe_stage_buf;

  logic        CLK = 1'b0;
  logic        RST;
  logic        inValid;
  logic [31:0] inData;
  logic        outReady;
  logic        flush;
  logic        hold;

  logic        ir0, ir1, ir2;
  logic        ov0, ov1, ov2;
  logic [31:0] od0, od1, od2;
  logic [1:0]  c0;
  logic [0:0]  c1;
  logic [1:0]  c2;
  logic [15:0] fd0;
  logic [1:0]  fd1;
  logic [1:0]  fd2;

  logic        dInReady  [3];
  logic        dOutValid [3];
  logic [31:0] dOutData  [3];
  logic [2:0]  dCount    [3];
  logic [15:0] dDrops    [3];

  int          depthOf  [3] = '{2, 1, 3};
  int          maxDrops [3] = '{65535, 3, 3};
  logic [31:0] bubbleOf [3] = '{32'h0, 32'h0000_0013, 32'h0};
  logic [31:0] mFifo    [3][4];
  int          mCnt     [3];
  int          mDrops   [3];

  int assertCount = 0;
  int failCount   = 0;

  always #5 CLK = ~CLK;

  pipe_stage_buf #(.DATA_W(32), .DEPTH(2), .BUBBLE_VAL(32'h0), .CNT_W(16)) u0 (
    .CLK(CLK), .RST(RST), .in_valid(inValid), .in_ready(ir0), .in_data(inData),
    .out_valid(ov0), .out_ready(outReady), .out_data(od0), .flush(flush), .hold(hold),
    .count(c0), .flush_drops(fd0));

  pipe_stage_buf #(.DATA_W(32), .DEPTH(1), .BUBBLE_VAL(32'h0000_0013), .CNT_W(2)) u1 (
    .CLK(CLK), .RST(RST), .in_valid(inValid), .in_ready(ir1), .in_data(inData),
    .out_valid(ov1), .out_ready(outReady), .out_data(od1), .flush(flush), .hold(hold),
    .count(c1), .flush_drops(fd1));

  pipe_stage_buf #(.DATA_W(32), .DEPTH(3), .BUBBLE_VAL(32'h0), .CNT_W(2)) u2 (
    .CLK(CLK), .RST(RST), .in_valid(inValid), .in_ready(ir2), .in_data(inData),
    .out_valid(ov2), .out_ready(outReady), .out_data(od2), .flush(flush), .hold(hold),
    .count(c2), .flush_drops(fd2));

  assign dInReady[0] = ir0;  assign dInReady[1] = ir1;  assign dInReady[2] = ir2;
  assign dOutValid[0] = ov0; assign dOutValid[1] = ov1; assign dOutValid[2] = ov2;
  assign dOutData[0] = od0;  assign dOutData[1] = od1;  assign dOutData[2] = od2;
  assign dCount[0] = 3'(c0); assign dCount[1] = 3'(c1); assign dCount[2] = 3'(c2);
  assign dDrops[0] = fd0;    assign dDrops[1] = 16'(fd1); assign dDrops[2] = 16'(fd2);

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 3; k++) begin
      mCnt[k]   = 0;
      mDrops[k] = 0;
    end
  endtask

  // Drives one cycle of inputs (called at a falling edge), checks every instance against
  // the model, then advances the model past the next rising edge.
  task automatic applyStimulus(input logic iv, input logic [31:0] din, input logic ordy,
                               input logic fl, input logic hd);
    logic rdy, vld, doPush, doPop;
    int   d, tmp;
    inValid = iv; inData = din; outReady = ordy; flush = fl; hold = hd;
    #1;
    for (int k = 0; k < 3; k++) begin
      d      = depthOf[k];
      rdy    = !hd && ((d >= 2) ? (mCnt[k] < d) : (mCnt[k] == 0 || ordy));
      vld    = (mCnt[k] > 0) && !hd;
      doPush = iv && rdy;
      doPop  = vld && ordy;
      checkOutput($sformatf("u%0d.count", k), 64'(dCount[k]), 64'(mCnt[k]));
      checkOutput($sformatf("u%0d.in_ready", k), 64'(dInReady[k]), 64'(rdy));
      checkOutput($sformatf("u%0d.out_valid", k), 64'(dOutValid[k]), 64'(vld));
      checkOutput($sformatf("u%0d.out_data", k), 64'(dOutData[k]),
                  64'((mCnt[k] > 0) ? mFifo[k][0] : bubbleOf[k]));
      checkOutput($sformatf("u%0d.flush_drops", k), 64'(dDrops[k]), 64'(mDrops[k]));
      if (fl) begin
        tmp = mDrops[k] + mCnt[k] - int'(doPop);
        mDrops[k] = (tmp > maxDrops[k]) ? maxDrops[k] : tmp;
        mCnt[k] = 0;
      end else begin
        if (doPop) begin
          for (int j = 0; j < 3; j++) mFifo[k][j] = mFifo[k][j+1];
          mCnt[k]--;
        end
        if (doPush) begin
          mFifo[k][mCnt[k]] = din;
          mCnt[k]++;
        end
      end
    end
    @(negedge CLK);
  endtask

  initial begin
    RST = 1'b1; inValid = 0; inData = 0; outReady = 0; flush = 0; hold = 0;
    modelReset();
    @(negedge CLK);
    @(negedge CLK);
    checkOutput("rst.count", 64'(c0), 64'd0);
    checkOutput("rst.out_valid", 64'(ov0), 64'd0);
    checkOutput("rst.out_data", 64'(od0), 64'd0);
    checkOutput("rst.in_ready", 64'(ir0), 64'd1);
    checkOutput("rst.bubble_u1", 64'(od1), 64'h13);
    RST = 1'b0;
    @(negedge CLK);

    applyStimulus(1, 32'hA5A5_A5A5, 0, 0, 0);
    checkOutput("push.out_valid", 64'(ov0), 64'd1);
    checkOutput("push.out_data", 64'(od0), 64'hA5A5_A5A5);
    checkOutput("push.count", 64'(c0), 64'd1);
    applyStimulus(0, 0, 1, 0, 0);

    applyStimulus(1, 32'h11, 0, 0, 0);
    applyStimulus(1, 32'h22, 0, 0, 0);
    applyStimulus(1, 32'h33, 0, 0, 0);
    checkOutput("bp.count", 64'(c0), 64'd2);
    checkOutput("bp.in_ready", 64'(ir0), 64'd0);
    checkOutput("bp.head", 64'(od0), 64'h11);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("bp.second", 64'(od0), 64'h22);
    checkOutput("bp.count1", 64'(c0), 64'd1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 0);

    applyStimulus(1, 32'd0, 1, 0, 0);
    for (int i = 1; i < 16; i++) begin
      applyStimulus(1, 32'(i), 1, 0, 0);
      for (int k = 0; k < 3; k++) begin
        checkOutput($sformatf("stream.u%0d.count", k), 64'(dCount[k]), 64'd1);
        checkOutput($sformatf("stream.u%0d.data", k), 64'(dOutData[k]), 64'(i));
      end
    end
    applyStimulus(0, 0, 1, 0, 0);

    applyStimulus(1, 32'hC1, 0, 0, 0);
    applyStimulus(1, 32'hC2, 0, 0, 0);
    checkOutput("flush.pre_count", 64'(c0), 64'd2);
    applyStimulus(1, 32'h99, 1, 1, 0);
    checkOutput("flush.count", 64'(c0), 64'd0);
    checkOutput("flush.out_valid", 64'(ov0), 64'd0);
    checkOutput("flush.out_data", 64'(od0), 64'd0);
    checkOutput("flush.drops", 64'(fd0), 64'd1);
    checkOutput("flush.bubble_u1", 64'(od1), 64'h13);

    for (int r = 0; r < 4; r++) begin
      applyStimulus(1, 32'(100 + r), 0, 0, 0);
      applyStimulus(1, 32'(200 + r), 0, 0, 0);
      applyStimulus(0, 0, 0, 1, 0);
    end
    checkOutput("sat.u1_drops", 64'(fd1), 64'd3);
    checkOutput("sat.u2_drops", 64'(fd2), 64'd3);
    checkOutput("sat.u0_drops", 64'(fd0), 64'd9);

    applyStimulus(1, 32'h77, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 32'h88, 1, 0, 1);
      checkOutput("hold.out_valid", 64'(ov0), 64'd0);
      checkOutput("hold.in_ready", 64'(ir0), 64'd0);
      checkOutput("hold.count", 64'(c0), 64'd1);
      checkOutput("hold.out_data", 64'(od0), 64'h77);
    end
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("hold.release_count", 64'(c0), 64'd0);

    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(99) < 70), $urandom, ($urandom_range(99) < 60),
                    ($urandom_range(99) < 5), ($urandom_range(99) < 10));
    end

    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(1, 32'hE1, 0, 0, 0);
    applyStimulus(1, 32'hE2, 0, 0, 0);
    inValid = 0; outReady = 0; flush = 0; hold = 0;
    checkOutput("arst.pre_count", 64'(c0), 64'd2);
    #2 RST = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("arst.u%0d.count", k), 64'(dCount[k]), 64'd0);
      checkOutput($sformatf("arst.u%0d.out_valid", k), 64'(dOutValid[k]), 64'd0);
      checkOutput($sformatf("arst.u%0d.drops", k), 64'(dDrops[k]), 64'd0);
      checkOutput($sformatf("arst.u%0d.out_data", k), 64'(dOutData[k]), 64'(bubbleOf[k]));
    end
    #1 RST = 1'b0;
    modelReset();
    @(negedge CLK);
    applyStimulus(1, 32'h5151, 0, 0, 0);
    applyStimulus(1, 32'h5252, 1, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
